// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multiport register file.
// Holds the sweep/run state enum and the default WIDTH/NREGS values.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREGS = 16;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port with PC substitution and write bypass.
// Ports: ra (address), clear (file not yet initialised), we3/wa3/wd3 and
// we4/wa4/wd4 (in-flight writes), r15 (PC value), q (stored word), rd (result).
module regfile_rdport #(
    parameter int WIDTH  = 32,
    parameter int AW     = 4,
    parameter int PC_IDX = 15
) (
    input  logic [AW-1:0]    ra,
    input  logic             clear,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic             we4,
    input  logic [AW-1:0]    wa4,
    input  logic [WIDTH-1:0] wd4,
    input  logic [WIDTH-1:0] r15,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rd
);

    // PC wins over everything; port B bypass wins over port A, matching
    // the store priority so a same-cycle read sees what will be written.
    always_comb begin
        rd = q;
        if (ra == AW'(PC_IDX)) begin
            rd = r15;
        end else if (clear) begin
            rd = '0;
        end else if (we4 && (wa4 == ra)) begin
            rd = wd4;
        end else if (we3 && (wa3 == ra)) begin
            rd = wd3;
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Three-read / two-write register file with a post-reset clearing sweep.
// Ports: clk, reset (async high), we3/wa3/wd3, we4/wa4/wd4, ra1..ra3,
// r15 (PC+8), rd1..rd3 (read data), ready (initialised and accepting writes).
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int  WIDTH  = DEF_WIDTH,
    parameter int  NREGS  = DEF_NREGS,
    parameter int  PC_IDX = NREGS - 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic             we4,
    input  logic [AW-1:0]    wa4,
    input  logic [WIDTH-1:0] wd4,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic [AW-1:0]    ra3,
    input  logic [WIDTH-1:0] r15,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic [WIDTH-1:0] rd3,
    output logic             ready
);

    rf_state_e        state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rf [NREGS];
    logic             clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN:     cnt_d = '0;
            default: state_d = CLEAR;
        endcase
    end

    assign clear = (state_q == CLEAR);
    assign ready = ~clear;

    // No reset term: contents are only zeroed by the sweep. Port B is
    // written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (clear) begin
            rf[cnt_q] <= '0;
        end else begin
            if (we3 && (wa3 != AW'(PC_IDX))) rf[wa3] <= wd3;
            if (we4 && (wa4 != AW'(PC_IDX))) rf[wa4] <= wd4;
        end
    end

    regfile_rdport #(.WIDTH(WIDTH), .AW(AW), .PC_IDX(PC_IDX)) u_rd1 (
        .ra(ra1), .clear(clear),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .we4(we4), .wa4(wa4), .wd4(wd4),
        .r15(r15), .q(rf[ra1]), .rd(rd1)
    );

    regfile_rdport #(.WIDTH(WIDTH), .AW(AW), .PC_IDX(PC_IDX)) u_rd2 (
        .ra(ra2), .clear(clear),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .we4(we4), .wa4(wa4), .wd4(wd4),
        .r15(r15), .q(rf[ra2]), .rd(rd2)
    );

    regfile_rdport #(.WIDTH(WIDTH), .AW(AW), .PC_IDX(PC_IDX)) u_rd3 (
        .ra(ra3), .clear(clear),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .we4(we4), .wa4(wa4), .wd4(wd4),
        .r15(r15), .q(rf[ra3]), .rd(rd3)
    );

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport (default and NREGS=8/WIDTH=16).
// Stimulus pushes expected reads; a negedge monitor pops and compares.
module tb_regfile_multiport;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0;
    logic        we3 = 1'b0, we4 = 1'b0;
    logic [3:0]  wa3 = '0, wa4 = '0, ra1 = '0, ra2 = '0, ra3 = '0;
    logic [31:0] wd3 = '0, wd4 = '0, r15 = '0;
    logic [31:0] rd1, rd2, rd3;
    logic        ready;

    logic        reset_b = 1'b0;
    logic        we3_b = 1'b0, we4_b = 1'b0;
    logic [2:0]  wa3_b = '0, wa4_b = '0, ra1_b = '0, ra2_b = '0, ra3_b = '0;
    logic [15:0] wd3_b = '0, wd4_b = '0, r15_b = '0;
    logic [15:0] rd1_b, rd2_b, rd3_b;
    logic        ready_b;

    regfile_multiport dut (
        .clk(clk), .reset(reset),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .we4(we4), .wa4(wa4), .wd4(wd4),
        .ra1(ra1), .ra2(ra2), .ra3(ra3), .r15(r15),
        .rd1(rd1), .rd2(rd2), .rd3(rd3), .ready(ready)
    );

    regfile_multiport #(.WIDTH(16), .NREGS(8)) dut8 (
        .clk(clk), .reset(reset_b),
        .we3(we3_b), .wa3(wa3_b), .wd3(wd3_b),
        .we4(we4_b), .wa4(wa4_b), .wd4(wd4_b),
        .ra1(ra1_b), .ra2(ra2_b), .ra3(ra3_b), .r15(r15_b),
        .rd1(rd1_b), .rd2(rd2_b), .rd3(rd3_b), .ready(ready_b)
    );

    typedef struct {
        int          id;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] rd3;
        logic        rdy;
    } exp_t;

    exp_t        sbq[$];
    int          tests = 0;
    int          fails = 0;
    int          step_id = 0;
    logic [31:0] mem [16];
    int          edges = 0;

    task automatic cmp(input string nm, input int id,
                       input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %h expected %h", nm, id, got, exp);
        end
    endtask

    // Reference view: file is usable once 16 unreset edges have elapsed.
    function automatic logic [31:0] model_read(input logic [3:0] ra);
        if (ra == 4'd15) return r15;
        if (edges < 16) return 32'h0;
        if (we4 && wa4 == ra) return wd4;
        if (we3 && wa3 == ra) return wd3;
        return mem[ra];
    endfunction

    task automatic step(input logic rs,
                        input logic w3, input logic [3:0] a3, input logic [31:0] d3,
                        input logic w4, input logic [3:0] a4, input logic [31:0] d4,
                        input logic [3:0] r1, input logic [3:0] r2,
                        input logic [3:0] r3, input logic [31:0] pc);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rs;
        we3 = w3; wa3 = a3; wd3 = d3;
        we4 = w4; wa4 = a4; wd4 = d4;
        ra1 = r1; ra2 = r2; ra3 = r3; r15 = pc;
        if (rs) edges = 0;
        step_id++;
        e.id  = step_id;
        e.rd1 = model_read(r1);
        e.rd2 = model_read(r2);
        e.rd3 = model_read(r3);
        e.rdy = (edges >= 16);
        sbq.push_back(e);
        // Effect of the coming rising edge.
        if (!rs) begin
            if (edges < 16) begin
                edges++;
                if (edges == 16) begin
                    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
                end
            end else begin
                if (w3 && a3 != 4'd15) mem[a3] = d3;
                if (w4 && a4 != 4'd15) mem[a4] = d4;
            end
        end
    endtask

    task automatic idle(input logic rs, input logic [3:0] r1,
                        input logic [3:0] r2, input logic [3:0] r3);
        step(rs, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, r1, r2, r3, 32'hC0DE_0008);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                cmp("rd1", e.id, rd1, e.rd1);
                cmp("rd2", e.id, rd2, e.rd2);
                cmp("rd3", e.id, rd3, e.rd3);
                cmp("ready", e.id, {31'h0, ready}, {31'h0, e.rdy});
            end
        end
    end

    initial begin : stim
        logic [31:0] v;
        #2 reset = 1'b1;
        idle(1'b1, 4'd3, 4'd15, 4'd0);
        idle(1'b1, 4'd3, 4'd15, 4'd0);

        // Release: 16 not-ready cycles, then ready; reg 3 reads zero throughout.
        for (int i = 0; i < 18; i++) idle(1'b0, 4'd3, 4'd15, 4'd4);

        // Same-cycle bypass, then stored value.
        step(1'b0, 1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'h0,
             4'd0, 4'd5, 4'd5, 32'h1008);
        idle(1'b0, 4'd1, 4'd5, 4'd2);

        // Collision: port B wins.
        step(1'b0, 1'b1, 4'd7, 32'h1111_1111, 1'b1, 4'd7, 32'h2222_2222,
             4'd7, 4'd7, 4'd6, 32'h1008);
        idle(1'b0, 4'd7, 4'd5, 4'd7);

        // Write to PC index is discarded; all ports read r15.
        step(1'b0, 1'b1, 4'd15, 32'h55, 1'b0, 4'd0, 32'h0,
             4'd15, 4'd15, 4'd15, 32'h0000_1008);
        step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,
             4'd15, 4'd15, 4'd15, 32'h0000_1008);

        // Reset mid-run, then reset again at sweep count 6 with writes issued.
        idle(1'b1, 4'd5, 4'd7, 4'd15);
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 4'd3, 32'hA5A5_0000 + i, 1'b0, 4'd0, 32'h0,
                 4'd3, 4'd5, 4'd15, 32'h1008);
        idle(1'b1, 4'd3, 4'd5, 4'd7);
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b1, 4'd3, 32'h5A5A_0000 + i, 1'b1, 4'd4, 32'h77,
                 4'd3, 4'd4, 4'd15, 32'h1008);
        idle(1'b0, 4'd3, 4'd4, 4'd5);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            v = $urandom;
            step(($urandom_range(0, 79) == 0),
                 v[0], 4'($urandom_range(0, 15)), $urandom,
                 v[1], 4'($urandom_range(0, 15)), $urandom,
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), $urandom);
        end
        idle(1'b0, 4'd0, 4'd1, 4'd2);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end

        // Reduced configuration: NREGS=8, WIDTH=16, PC_IDX=7.
        reset_b = 1'b1;
        ra2_b = 3'd2;
        @(posedge clk);
        #1 reset_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cmp("p8_ready_clear", i, {31'h0, ready_b}, 32'h0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        cmp("p8_ready_run", 0, {31'h0, ready_b}, 32'h1);
        cmp("p8_rd2_zero", 0, {16'h0, rd2_b}, 32'h0);
        @(posedge clk);
        #1;
        ra1_b = 3'd7; r15_b = 16'h1234;
        we3_b = 1'b1; wa3_b = 3'd5; wd3_b = 16'hBEEF; ra2_b = 3'd5;
        @(negedge clk);
        cmp("p8_pc", 0, {16'h0, rd1_b}, 32'h1234);
        cmp("p8_bypass", 0, {16'h0, rd2_b}, 32'hBEEF);
        @(posedge clk);
        #1 we3_b = 1'b0;
        @(negedge clk);
        cmp("p8_stored", 0, {16'h0, rd2_b}, 32'hBEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
